powlib_spram_arb: RTL and testbench

POWLIB_SPRAM_ARB -- requirements
Module: powlib_spram_arb

---
 rtl/powlib_spram_arb_if.sv | 42 ++++
 rtl/powlib_spram_arb.sv | 168 ++++++++++++++++
 tb/tb_powlib_spram_arb.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/powlib_spram_arb_if.sv
// Sizing helper and the requester/response bundle for the arbitrated single-port RAM.
package powlib_spram_arb_pkg;

    // Bits needed to hold the value itself (8 -> 4), so an index port can also express D.
    function automatic int unsigned powlib_clogb2(input int unsigned value);
        int unsigned v;
        int unsigned n;
        v = value;
        n = 0;
        while (v > 0) begin
            n++;
            v = v >> 1;
        end
        return n;
    endfunction

endpackage

interface powlib_spram_arb_if #(
    parameter int unsigned W    = 16,
    parameter int unsigned NR   = 4,
    parameter int unsigned WIDX = 4
);
    logic [NR-1:0]      reqvld;
    logic [NR-1:0]      reqrdy;
    logic [NR-1:0]      reqwr;
    logic [NR-1:0]      reqlock;
    logic [NR*WIDX-1:0] reqidx;
    logic [NR*W-1:0]    reqdata;
    logic [NR-1:0]      rspvld;
    logic [W-1:0]       rspdata;

    modport master (
        output reqvld, reqwr, reqlock, reqidx, reqdata,
        input  reqrdy, rspvld, rspdata
    );

    modport slave (
        input  reqvld, reqwr, reqlock, reqidx, reqdata,
        output reqrdy, rspvld, rspdata
    );
endinterface

// File: rtl/powlib_spram_arb.sv
// Round-robin arbiter with bounded lock bursts in front of one single-port RAM
// (asynchronous read, write on the clock edge, registered read response).
module powlib_spram #(
    parameter int unsigned     W    = 16,
    parameter int unsigned     D    = 8,
    parameter int unsigned     WIDX = 4,
    parameter logic [W*D-1:0]  INIT = '0
) (
    input  logic            clk,
    input  logic            wr_i,
    input  logic [WIDX-1:0] idx_i,
    input  logic [W-1:0]    data_i,
    output logic [W-1:0]    rdata_c_o
);
    // Words are stored as the difference from INIT, so the all-zero power-up state reads back INIT.
    logic [W*D-1:0] mem_q;

    always_ff @(posedge clk) begin
        for (int j = 0; j < int'(D); j++) begin
            if (wr_i && idx_i == WIDX'(j)) mem_q[j*W +: W] <= data_i ^ INIT[j*W +: W];
        end
    end

    // Indices at or beyond D match no word and read as zero.
    always_comb begin
        rdata_c_o = '0;
        for (int j = 0; j < int'(D); j++) begin
            if (idx_i == WIDX'(j)) rdata_c_o = mem_q[j*W +: W] ^ INIT[j*W +: W];
        end
    end
endmodule

module powlib_spram_arb
    import powlib_spram_arb_pkg::*;
#(
    parameter int unsigned    W    = 16,
    parameter int unsigned    D    = 8,
    parameter int unsigned    WIDX = powlib_clogb2(D),
    parameter int unsigned    NR   = 4,
    parameter int unsigned    WNR  = powlib_clogb2(NR),
    parameter int unsigned    MAXB = 4,
    parameter logic [W*D-1:0] INIT = '0
) (
    input  logic               clk,
    input  logic               rst,
    powlib_spram_arb_if.slave  bus
);
    localparam int unsigned WBC = 8;

    typedef enum logic {ST_ARB, ST_LOCK} state_t;

    state_t          state_q, state_d;
    logic [WNR-1:0]  ptr_q, ptr_d, own_q, own_d;
    logic [WBC-1:0]  bc_q, bc_d, bc_eff;
    logic [NR-1:0]   rspvld_q, rspvld_d, rdy_c;
    logic [W-1:0]    rspdata_q, rspdata_d, mem_rdata;
    logic            own_vld, hold, found, xfer, sel_wr, sel_lock;
    logic [WNR-1:0]  g, base;
    logic [WIDX-1:0] sel_idx;
    logic [W-1:0]    sel_data;
    int              best;

    function automatic logic [WNR-1:0] nxt(input logic [WNR-1:0] p);
        return (p == WNR'(NR - 1)) ? '0 : p + WNR'(1);
    endfunction

    // Winner selection: a live lock owner first, else nearest valid requester at or after base.
    always_comb begin
        own_vld  = 1'b0;
        found    = 1'b0;
        g        = '0;
        best     = int'(NR);
        sel_idx  = '0;
        sel_data = '0;
        sel_wr   = 1'b0;
        sel_lock = 1'b0;
        rdy_c    = '0;
        for (int i = 0; i < int'(NR); i++) begin
            if (own_q == WNR'(i)) own_vld = bus.reqvld[i];
        end
        hold = (state_q == ST_LOCK) && own_vld;
        base = (state_q == ST_LOCK) ? nxt(own_q) : ptr_q;
        if (hold) begin
            found = 1'b1;
            g     = own_q;
        end else begin
            for (int i = 0; i < int'(NR); i++) begin
                if (bus.reqvld[i] && ((i - int'(base) + int'(NR)) % int'(NR)) < best) begin
                    best  = (i - int'(base) + int'(NR)) % int'(NR);
                    g     = WNR'(i);
                    found = 1'b1;
                end
            end
        end
        xfer = found && !rst;
        for (int i = 0; i < int'(NR); i++) begin
            if (g == WNR'(i)) begin
                sel_idx  = bus.reqidx[i*WIDX +: WIDX];
                sel_data = bus.reqdata[i*W +: W];
                sel_wr   = bus.reqwr[i];
                sel_lock = bus.reqlock[i];
                rdy_c[i] = xfer;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        own_d     = own_q;
        bc_d      = bc_q;
        bc_eff    = hold ? bc_q : '0;
        rspvld_d  = '0;
        rspdata_d = rspdata_q;
        // Owner dropped its request: release and restart the rotation just past it.
        if (state_q == ST_LOCK && !hold) begin
            state_d = ST_ARB;
            ptr_d   = base;
            bc_d    = '0;
        end
        if (xfer) begin
            if (!sel_wr) begin
                rspvld_d  = rdy_c;
                rspdata_d = mem_rdata;
            end
            if (sel_lock && bc_eff < WBC'(MAXB - 1)) begin
                state_d = ST_LOCK;
                own_d   = g;
                bc_d    = bc_eff + WBC'(1);
            end else begin
                state_d = ST_ARB;
                bc_d    = '0;
                ptr_d   = nxt(g);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ARB;
            ptr_q     <= '0;
            own_q     <= '0;
            bc_q      <= '0;
            rspvld_q  <= '0;
            rspdata_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            own_q     <= own_d;
            bc_q      <= bc_d;
            rspvld_q  <= rspvld_d;
            rspdata_q <= rspdata_d;
        end
    end

    powlib_spram #(.W(W), .D(D), .WIDX(WIDX), .INIT(INIT)) u_mem (
        .clk       (clk),
        .wr_i      (xfer && sel_wr),
        .idx_i     (sel_idx),
        .data_i    (sel_data),
        .rdata_c_o (mem_rdata)
    );

    // A response in flight when reset arrives is suppressed for the reset cycle.
    assign bus.reqrdy  = rdy_c;
    assign bus.rspvld  = rst ? '0 : rspvld_q;
    assign bus.rspdata = rst ? '0 : rspdata_q;
endmodule

// File: tb/tb_powlib_spram_arb.sv
// Randomized and directed bench for powlib_spram_arb with a queue-based response scoreboard.
module tb_powlib_spram_arb;
    import powlib_spram_arb_pkg::*;

    localparam int W    = 16;
    localparam int D    = 8;
    localparam int NR   = 4;
    localparam int MAXB = 4;
    localparam int WIDX = int'(powlib_clogb2(D));
    localparam int WNR  = int'(powlib_clogb2(NR));

    function automatic logic [W*D-1:0] mk_init();
        logic [W*D-1:0] r;
        for (int j = 0; j < D; j++) r[j*W +: W] = W'(16'h1000 + j * 16'h0101);
        return r;
    endfunction
    localparam logic [W*D-1:0] INIT = mk_init();

    typedef struct {
        int            due;
        logic [NR-1:0] vld;
        logic [W-1:0]  data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    rsp_t sb[$];
    rsp_t mon_e;

    logic [W-1:0]       m_mem [D];
    int                 m_ptr, m_owner, m_run;
    logic [W-1:0]       m_last;
    logic [NR-1:0]      d_wr, d_lk;
    logic [NR*WIDX-1:0] d_idx;
    logic [NR*W-1:0]    d_dat;

    powlib_spram_arb_if #(.W(W), .NR(NR), .WIDX(WIDX)) bus ();

    powlib_spram_arb #(
        .W(W), .D(D), .WIDX(WIDX), .NR(NR), .WNR(WNR), .MAXB(MAXB), .INIT(INIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic lk, input int idx,
                           input logic [W-1:0] dat);
        d_wr[i]             = wr;
        d_lk[i]             = lk;
        d_idx[i*WIDX +: WIDX] = WIDX'(idx);
        d_dat[i*W +: W]     = dat;
    endtask

    // One clock: drive, check the grant against the model, advance the model.
    // exp_g: -2 = model only, -1 = no grant expected, else the literal winner.
    task automatic cycle(input logic [NR-1:0] v, input logic r, input int exp_g);
        int g;
        int idx;
        logic [NR-1:0] exp_rdy;
        @(posedge clk);
        #1;
        rst         = r;
        bus.reqvld  = v;
        bus.reqwr   = d_wr;
        bus.reqlock = d_lk;
        bus.reqidx  = d_idx;
        bus.reqdata = d_dat;
        #1;
        if (r) begin
            chk("rst_reqrdy", 64'(bus.reqrdy), 64'(0));
            chk("rst_rspvld", 64'(bus.rspvld), 64'(0));
            chk("rst_rspdata", 64'(bus.rspdata), 64'(0));
            sb.delete();
            m_ptr   = 0;
            m_owner = -1;
            m_run   = 0;
            m_last  = '0;
            return;
        end
        g = -1;
        if (m_owner >= 0 && v[m_owner]) begin
            g = m_owner;
        end else begin
            if (m_owner >= 0) begin
                m_ptr   = (m_owner + 1) % NR;
                m_owner = -1;
                m_run   = 0;
            end
            for (int k = 0; k < NR; k++)
                if (g < 0 && v[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        end
        exp_rdy = (g >= 0) ? NR'(1) << g : '0;
        chk("reqrdy", 64'(bus.reqrdy), 64'(exp_rdy));
        if (exp_g != -2) chk("grant_seq", 64'(bus.reqrdy), 64'((exp_g < 0) ? '0 : NR'(1) << exp_g));
        if (g >= 0) begin
            idx = int'(d_idx[g*WIDX +: WIDX]);
            if (d_wr[g]) begin
                if (idx < D) m_mem[idx] = d_dat[g*W +: W];
            end else begin
                sb.push_back('{due: cyc + 1, vld: NR'(1) << g, data: (idx < D) ? m_mem[idx] : '0});
            end
            m_run = (m_owner == g) ? m_run + 1 : 1;
            if (d_lk[g] && m_run < MAXB) begin
                m_owner = g;
            end else begin
                m_owner = -1;
                m_run   = 0;
                m_ptr   = (g + 1) % NR;
            end
        end
    endtask

    // Response monitor: every rspvld pulse must match the oldest expected read.
    always @(negedge clk) begin
        if (bus.rspvld != '0) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL rsp_unexpected @cyc %0d: got rspvld=%b expected none", cyc, bus.rspvld);
            end else begin
                mon_e = sb.pop_front();
                chk("rspvld", 64'(bus.rspvld), 64'(mon_e.vld));
                chk("rspdata", 64'(bus.rspdata), 64'(mon_e.data));
                chk("rsp_latency", 64'(cyc), 64'(mon_e.due));
                m_last = mon_e.data;
            end
        end else begin
            chk("rspdata_hold", 64'(bus.rspdata), 64'(m_last));
            if (sb.size() != 0 && sb[0].due <= cyc) begin
                n_chk++;
                n_err++;
                $display("FAIL rsp_missing @cyc %0d: got no rspvld expected %b", cyc, sb[0].vld);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        for (int j = 0; j < D; j++) m_mem[j] = INIT[j*W +: W];
        m_ptr = 0; m_owner = -1; m_run = 0; m_last = '0;
        d_wr = '0; d_lk = '0; d_idx = '0; d_dat = '0;
        bus.reqvld = '0; bus.reqwr = '0; bus.reqlock = '0; bus.reqidx = '0; bus.reqdata = '0;
        repeat (3) @(posedge clk);
        cycle('0, 1'b1, -2);

        // Plain rotation among four readers.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, int'($urandom_range(0, D - 1)), '0);
            cycle(4'b1111, 1'b0, k % NR);
        end

        // Write then read-back of the same index by a different requester.
        set_req(2, 1'b1, 1'b0, 5, 16'hBEEF);
        cycle(4'b0100, 1'b0, 2);
        set_req(0, 1'b0, 1'b0, 5, '0);
        cycle(4'b0001, 1'b0, 0);
        cycle('0, 1'b0, -1);

        // Locked burst capped at MAXB, then rotation resumes.
        set_req(0, 1'b0, 1'b0, 1, '0);
        set_req(1, 1'b0, 1'b1, 2, '0);
        set_req(3, 1'b0, 1'b0, 3, '0);
        for (int k = 0; k < 4; k++) cycle(4'b1011, 1'b0, 1);
        cycle(4'b1011, 1'b0, 3);
        cycle(4'b1011, 1'b0, 0);

        // Lock owner drops its request: another requester wins in the same cycle.
        cycle(4'b1010, 1'b0, 1);
        cycle(4'b1000, 1'b0, 3);
        set_req(1, 1'b0, 1'b0, 2, '0);
        set_req(2, 1'b0, 1'b0, 4, '0);
        cycle(4'b1111, 1'b0, 0);

        // Read accepted right before reset yields no response.
        cycle(4'b0100, 1'b0, 2);
        cycle(4'b0100, 1'b1, -2);
        cycle(4'b1110, 1'b0, 1);

        // Out-of-range write is dropped, out-of-range read returns zero.
        set_req(1, 1'b1, 1'b0, D, 16'hDEAD);
        cycle(4'b0010, 1'b0, 1);
        set_req(2, 1'b0, 1'b0, D, '0);
        cycle(4'b0100, 1'b0, 2);
        for (int j = 0; j < D; j++) begin
            set_req(0, 1'b0, 1'b0, j, '0);
            cycle(4'b0001, 1'b0, 0);
        end

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NR; i++)
                set_req(i, 1'($urandom % 2), 1'(($urandom % 3) != 0),
                        int'($urandom_range(0, D + 1)), W'($urandom));
            cycle(NR'($urandom), 1'($urandom % 60 == 0), -2);
        end

        for (int k = 0; k < 3; k++) cycle('0, 1'b0, -1);
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
